// File: rtl/mm2s_line_reader.sv
// Read-side sequencer for the double-buffered mm2s line store. It walks one line buffer
// at a time, absorbs the RAM's one-cycle read latency and emits pixels as AXI4-Stream video.
module mm2s_line_reader #(
    parameter int C_PIXEL_WIDTH = 8,
    parameter int C_IMG_WBITS   = 12,
    parameter int C_IMG_HBITS   = 12,
    parameter int C_ADDR_WIDTH  = C_IMG_WBITS + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [C_IMG_WBITS-1:0]   img_width,
    input  logic [C_IMG_HBITS-1:0]   img_height,
    input  logic                     line_written,
    output logic                     line_consumed,
    output logic                     busy,
    output logic                     ram_re,
    output logic [C_ADDR_WIDTH-1:0]  ram_ra,
    input  logic [C_PIXEL_WIDTH-1:0] ram_rd,
    output logic                     m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_LINE,
        S_READ_LINE,
        S_DRAIN
    } state_t;

    localparam logic [C_IMG_WBITS-1:0] ONE_W = 1;
    localparam logic [C_IMG_HBITS-1:0] ONE_H = 1;

    state_t                 state_q, state_d;
    logic [C_IMG_WBITS-1:0] width_q, width_d;
    logic [C_IMG_HBITS-1:0] height_q, height_d;
    logic [C_IMG_HBITS-1:0] row_q, row_d;
    logic [C_IMG_WBITS-1:0] col_q, col_d;
    logic                   buf_sel_q, buf_sel_d;
    logic [1:0]             pending_q, pending_d;
    logic                   line_consumed_q, line_consumed_d;

    // Read issued last cycle; its pixel arrives on ram_rd this cycle.
    logic                   infl_q, infl_user_q, infl_last_q;

    logic [C_PIXEL_WIDTH-1:0] fifo_data_q [2];
    logic [1:0]             fifo_user_q, fifo_last_q;
    logic                   fifo_wr_q, fifo_rd_q;
    logic [1:0]             fifo_cnt_q;

    logic                   pop, read_ok, last_col, drain_done;
    logic                   issue_user, issue_last;
    logic [1:0]             occ_after;

    assign pop        = (fifo_cnt_q != 2'd0) && m_axis_tready;
    assign occ_after  = fifo_cnt_q + {1'b0, infl_q} - {1'b0, pop};
    assign read_ok    = occ_after < 2'd2;
    assign last_col   = (col_q + ONE_W) == width_q;
    assign drain_done = (fifo_cnt_q == 2'd0) && !infl_q;
    assign issue_user = (row_q == '0) && (col_q == '0);
    assign issue_last = last_col;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        state_d         = state_q;
        width_d         = width_q;
        height_d        = height_q;
        row_d           = row_q;
        col_d           = col_q;
        buf_sel_d       = buf_sel_q;
        line_consumed_d = 1'b0;
        ram_re          = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && (img_width != '0) && (img_height != '0)) begin
                    width_d  = img_width;
                    height_d = img_height;
                    row_d    = '0;
                    col_d    = '0;
                    state_d  = S_WAIT_LINE;
                end
            end
            S_WAIT_LINE: begin
                // A release still being pulsed has not left pending_q yet.
                if (pending_q > {1'b0, line_consumed_q}) state_d = S_READ_LINE;
            end
            S_READ_LINE: begin
                if (read_ok) begin
                    ram_re = 1'b1;
                    if (last_col) begin
                        col_d           = '0;
                        line_consumed_d = 1'b1;
                        buf_sel_d       = ~buf_sel_q;
                        row_d           = row_q + ONE_H;
                        state_d         = (row_q == height_q - ONE_H) ? S_DRAIN : S_WAIT_LINE;
                    end else begin
                        col_d = col_q + ONE_W;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pending_d = pending_q;
        case ({line_written, line_consumed_q})
            2'b10:   if (pending_q != 2'd2) pending_d = pending_q + 2'd1;
            2'b01:   pending_d = pending_q - 2'd1;
            default: pending_d = pending_q;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            width_q         <= '0;
            height_q        <= '0;
            row_q           <= '0;
            col_q           <= '0;
            buf_sel_q       <= 1'b0;
            pending_q       <= 2'd0;
            line_consumed_q <= 1'b0;
            infl_q          <= 1'b0;
            infl_user_q     <= 1'b0;
            infl_last_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            width_q         <= width_d;
            height_q        <= height_d;
            row_q           <= row_d;
            col_q           <= col_d;
            buf_sel_q       <= buf_sel_d;
            pending_q       <= pending_d;
            line_consumed_q <= line_consumed_d;
            infl_q          <= ram_re;
            if (ram_re) begin
                infl_user_q <= issue_user;
                infl_last_q <= issue_last;
            end
        end
    end

    // NOTE: the two-entry FIFO storage is reset so the stream outputs read zero out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_user_q    <= '0;
            fifo_last_q    <= '0;
            fifo_wr_q      <= 1'b0;
            fifo_rd_q      <= 1'b0;
            fifo_cnt_q     <= 2'd0;
        end else begin
            if (infl_q) begin
                fifo_data_q[fifo_wr_q] <= ram_rd;
                fifo_user_q[fifo_wr_q] <= infl_user_q;
                fifo_last_q[fifo_wr_q] <= infl_last_q;
                fifo_wr_q              <= ~fifo_wr_q;
            end
            if (pop) fifo_rd_q <= ~fifo_rd_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, infl_q} - {1'b0, pop};
        end
    end

    assign ram_ra        = {buf_sel_q, col_q};
    assign line_consumed = line_consumed_q;
    assign busy          = (state_q != S_IDLE) && !((state_q == S_DRAIN) && drain_done);
    assign m_axis_tvalid = fifo_cnt_q != 2'd0;
    assign m_axis_tdata  = fifo_data_q[fifo_rd_q];
    assign m_axis_tuser  = fifo_user_q[fifo_rd_q];
    assign m_axis_tlast  = fifo_last_q[fifo_rd_q];

endmodule

// File: tb/tb_mm2s_line_reader.sv
// Scoreboard bench for mm2s_line_reader: expected addresses and beats are queued when a
// frame is started and compared as the DUT issues reads and completes stream handshakes.
module tb_mm2s_line_reader;

    typedef struct packed {
        logic [7:0] data;
        logic       user;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] img_width = '0;
    logic [11:0] img_height = '0;
    logic        line_written = 1'b0;
    logic        line_consumed;
    logic        busy;
    logic        ram_re;
    logic [12:0] ram_ra;
    logic [7:0]  ram_rd = '0;
    logic        m_axis_tvalid;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;

    mm2s_line_reader dut (
        .clk(clk), .reset(reset), .start(start),
        .img_width(img_width), .img_height(img_height),
        .line_written(line_written), .line_consumed(line_consumed), .busy(busy),
        .ram_re(ram_re), .ram_ra(ram_ra), .ram_rd(ram_rd),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pix(input logic [12:0] a);
        return {a[12], a[6:0]} ^ 8'h5A;
    endfunction

    // RAM narrow read port: registered, one-cycle latency.
    always @(posedge clk) if (ram_re) ram_rd <= pix(ram_ra);

    int    checks = 0;
    int    failures = 0;
    beat_t exp_beats [$];
    logic [12:0] exp_addr [$];
    logic  tb_buf = 1'b0;

    logic  mon_en = 1'b0;
    int    occ = 0, infl = 0;
    logic  hs, prev_stall = 1'b0;
    logic [7:0] sv_data;
    logic  sv_user, sv_last;
    int    re_cnt = 0, lc_cnt = 0, stall_cnt = 0;
    int    first_re = -1, first_v = -1, last_hs_cyc = -1;
    int    ready_mode = 0;

    initial begin : monitor
        beat_t       eb;
        logic [12:0] ea;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                hs = m_axis_tvalid && m_axis_tready;
                if (prev_stall) begin
                    checks++;
                    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== sv_data ||
                        m_axis_tuser !== sv_user || m_axis_tlast !== sv_last) begin
                        failures++;
                        $display("FAIL stall_hold: got v=%b d=%h u=%b l=%b, required v=1 d=%h u=%b l=%b",
                                 m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast,
                                 sv_data, sv_user, sv_last);
                    end
                end
                if (ram_re === 1'b1) begin
                    re_cnt++;
                    if (first_re < 0) first_re = cyc;
                    checks++;
                    if (exp_addr.size() == 0) begin
                        failures++;
                        $display("FAIL ram_ra: unexpected read at %h, required no read", ram_ra);
                    end else begin
                        ea = exp_addr.pop_front();
                        if (ram_ra !== ea) begin
                            failures++;
                            $display("FAIL ram_ra: got %h, required %h", ram_ra, ea);
                        end
                    end
                    checks++;
                    if (occ + infl - (hs ? 1 : 0) >= 2) begin
                        failures++;
                        $display("FAIL read_flow: read issued with occupancy+inflight=%0d, required <2",
                                 occ + infl - (hs ? 1 : 0));
                    end
                end
                if (m_axis_tvalid === 1'b1 && first_v < 0) first_v = cyc;
                if (hs) begin
                    last_hs_cyc = cyc;
                    checks++;
                    if (exp_beats.size() == 0) begin
                        failures++;
                        $display("FAIL beat: unexpected beat d=%h u=%b l=%b, required none",
                                 m_axis_tdata, m_axis_tuser, m_axis_tlast);
                    end else begin
                        eb = exp_beats.pop_front();
                        if (m_axis_tdata !== eb.data || m_axis_tuser !== eb.user ||
                            m_axis_tlast !== eb.last) begin
                            failures++;
                            $display("FAIL beat: got d=%h u=%b l=%b, required d=%h u=%b l=%b",
                                     m_axis_tdata, m_axis_tuser, m_axis_tlast,
                                     eb.data, eb.user, eb.last);
                        end
                    end
                end
                if (line_consumed === 1'b1) lc_cnt++;
                occ = occ + infl - (hs ? 1 : 0);
                infl = (ram_re === 1'b1) ? 1 : 0;
                prev_stall = m_axis_tvalid && !m_axis_tready;
                if (prev_stall) stall_cnt++;
                sv_data = m_axis_tdata;
                sv_user = m_axis_tuser;
                sv_last = m_axis_tlast;
            end
        end
    end

    initial begin : ready_driver
        int pat [4] = '{1, 0, 0, 1};
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode != 0) begin
                m_axis_tready = pat[ph][0];
                ph = (ph + 1) % 4;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic queue_frame(input int w, input int h);
        beat_t       b;
        logic [12:0] a;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                a = {tb_buf, 12'(c)};
                exp_addr.push_back(a);
                b.data = pix(a);
                b.user = (r == 0) && (c == 0);
                b.last = (c == w - 1);
                exp_beats.push_back(b);
            end
            tb_buf = ~tb_buf;
        end
    endtask

    task automatic pulse_lw(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 line_written = 1'b1;
            @(posedge clk); #1 line_written = 1'b0;
        end
    endtask

    task automatic do_start(input int w, input int h);
        @(posedge clk); #1;
        start = 1'b1;
        img_width = 12'(w);
        img_height = 12'(h);
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int fall);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        fall = cyc;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_done: busy=%b after %0d cycles, required 0", name, busy, budget);
        end
    endtask

    task automatic frame_checks(input string name, input int h);
        checks++;
        if (exp_beats.size() != 0) begin
            failures++;
            $display("FAIL %s_beats: %0d beats missing, required 0", name, exp_beats.size());
        end
        checks++;
        if (exp_addr.size() != 0) begin
            failures++;
            $display("FAIL %s_reads: %0d reads missing, required 0", name, exp_addr.size());
        end
        checks++;
        if (lc_cnt != h) begin
            failures++;
            $display("FAIL %s_consumed: got %0d pulses, required %0d", name, lc_cnt, h);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (busy !== 1'b0 || line_consumed !== 1'b0 || ram_re !== 1'b0 || ram_ra !== 13'h0 ||
            m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00 || m_axis_tuser !== 1'b0 ||
            m_axis_tlast !== 1'b0) begin
            failures++;
            $display("FAIL %s: got busy=%b lc=%b re=%b ra=%h v=%b d=%h u=%b l=%b, required all 0",
                     name, busy, line_consumed, ram_re, ram_ra, m_axis_tvalid, m_axis_tdata,
                     m_axis_tuser, m_axis_tlast);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_basic;
        int fall;
        lc_cnt = 0;
        first_re = -1;
        first_v = -1;
        pulse_lw(2);
        queue_frame(4, 2);
        do_start(4, 2);
        wait_done("basic", 200, fall);
        frame_checks("basic", 2);
        checks++;
        if (first_v - first_re != 2) begin
            failures++;
            $display("FAIL basic_latency: got %0d cycles, required 2", first_v - first_re);
        end
        checks++;
        if (fall != last_hs_cyc + 1) begin
            failures++;
            $display("FAIL basic_busy_fall: got cycle %0d, required %0d", fall, last_hs_cyc + 1);
        end
    endtask

    task automatic test_backpressure;
        int fall;
        lc_cnt = 0;
        stall_cnt = 0;
        ready_mode = 1;
        pulse_lw(2);
        queue_frame(4, 2);
        do_start(4, 2);
        wait_done("bp", 300, fall);
        ready_mode = 0;
        @(posedge clk); #1 m_axis_tready = 1'b1;
        frame_checks("bp", 2);
        checks++;
        if (stall_cnt == 0) begin
            failures++;
            $display("FAIL bp_stalls: got %0d stalled cycles, required >0", stall_cnt);
        end
    endtask

    task automatic test_stall_wait_line;
        int   n, snap, fall;
        logic line1_buf;
        lc_cnt = 0;
        line1_buf = ~tb_buf;
        pulse_lw(1);
        queue_frame(4, 3);
        do_start(4, 3);
        n = 0;
        while (lc_cnt < 1 && n < 100) begin @(negedge clk); n++; end
        snap = re_cnt;
        repeat (10) @(negedge clk);
        checks++;
        if (re_cnt != snap || busy !== 1'b1 || exp_addr.size() != 8) begin
            failures++;
            $display("FAIL stall_wait: got reads=%0d busy=%b left=%0d, required reads=0 busy=1 left=8",
                     re_cnt - snap, busy, exp_addr.size());
        end
        pulse_lw(1);
        n = 0;
        @(negedge clk);
        while (!(ram_re === 1'b1 && ram_ra === {line1_buf, 12'd3}) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1 line_written = 1'b1;
        checks++;
        if (line_consumed !== 1'b1) begin
            failures++;
            $display("FAIL stall_coincide: line_consumed=%b, required 1", line_consumed);
        end
        @(posedge clk); #1 line_written = 1'b0;
        wait_done("stall", 200, fall);
        frame_checks("stall", 3);
    endtask

    task automatic test_zero_dim;
        int snap = re_cnt;
        do_start(0, 2);
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_width_busy: got %b, required 0", busy);
        end
        do_start(4, 0);
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || re_cnt != snap) begin
            failures++;
            $display("FAIL zero_dim: got busy=%b reads=%0d, required busy=0 reads=0",
                     busy, re_cnt - snap);
        end
    endtask

    task automatic test_width1;
        int fall;
        lc_cnt = 0;
        pulse_lw(1);
        queue_frame(1, 1);
        do_start(1, 1);
        wait_done("w1", 100, fall);
        frame_checks("w1", 1);
    endtask

    task automatic test_reset_midline;
        int n = 0;
        int fall;
        int snap = re_cnt;
        lc_cnt = 0;
        pulse_lw(2);
        queue_frame(4, 2);
        do_start(4, 2);
        while (re_cnt < snap + 2 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        reset = 1'b1;
        mon_en = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("reset_midline");
        reset = 1'b0;
        exp_addr.delete();
        exp_beats.delete();
        occ = 0;
        infl = 0;
        prev_stall = 1'b0;
        tb_buf = 1'b0;
        mon_en = 1'b1;
        lc_cnt = 0;
        pulse_lw(1);
        queue_frame(2, 1);
        do_start(2, 1);
        wait_done("after_reset", 100, fall);
        frame_checks("after_reset", 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stall_wait_line();
        test_zero_dim();
        test_width1();
        test_reset_midline();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
